noc_inject_rr_arbiter: RTL and testbench



---
 rtl/noc_inject_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_noc_inject_rr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_rr_arbiter.sv
// Wormhole round-robin arbiter that merges NUM_REQ local flit sources onto one
// NoC injection port through a single registered output stage.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = `Noc_Data_Width,
  parameter int IDX_W   = 2
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [IDX_W-1:0]          owner,
  output logic                      locked,
  output logic [15:0]               pkt_cnt,
  output logic                      err_mid_header
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic                locked_q;
  logic                seen_flit_q;
  logic                out_valid_q;
  logic [FLIT_W-1:0]   out_flit_q;
  logic                out_is_header_q;
  logic                out_is_tail_q;
  logic [15:0]         pkt_cnt_q;
  logic                err_q;

  logic [FLIT_W-1:0]   flit_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  elig;
  logic [2*NUM_REQ-1:0] elig_rot;
  logic [IDX_W:0]      shamt;
  logic [IDX_W:0]      grant_sum;
  logic [IDX_W-1:0]    grant_d;
  logic                found_d;
  logic                can_load;
  logic                accept;
  logic                sel_header;
  logic                sel_tail;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign flit_arr[gi] = req_flit[gi*FLIT_W +: FLIT_W];
  end

  // Rotate the eligible vector so bit 0 is the requester right after last_grant.
  assign elig  = req_valid & req_is_header;
  assign shamt = {1'b0, last_grant_q} + {{IDX_W{1'b0}}, 1'b1};

  always_comb begin
    elig_rot  = {elig, elig} >> shamt;
    found_d   = 1'b0;
    grant_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        found_d   = 1'b1;
        grant_sum = shamt + (IDX_W+1)'(i);
      end
    end
    if (grant_sum >= (IDX_W+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (IDX_W+1)'(NUM_REQ);
    end
    grant_d = grant_sum[IDX_W-1:0];
  end

  assign can_load   = !out_valid_q || out_ready;
  assign accept     = (state_q == LOCK) && req_valid[owner_q] && can_load;
  assign sel_header = req_is_header[owner_q];
  assign sel_tail   = req_is_tail[owner_q];

  always_comb begin
    req_ready = '0;
    if (state_q == LOCK) begin
      req_ready[owner_q] = can_load;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q         <= IDLE;
      owner_q         <= IDX_W'(NUM_REQ - 1);
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      locked_q        <= 1'b0;
      seen_flit_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_flit_q      <= '0;
      out_is_header_q <= 1'b0;
      out_is_tail_q   <= 1'b0;
      pkt_cnt_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q     <= LOCK;
            owner_q     <= grant_d;
            locked_q    <= 1'b1;
            seen_flit_q <= 1'b0;
          end
        end
        LOCK: begin
          if (accept) begin
            seen_flit_q <= 1'b1;
            // A header after the packet's first flit is still forwarded.
            if (sel_header && seen_flit_q) begin
              err_q <= 1'b1;
            end
            if (sel_tail) begin
              state_q      <= IDLE;
              locked_q     <= 1'b0;
              last_grant_q <= owner_q;
              pkt_cnt_q    <= pkt_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        out_valid_q     <= 1'b1;
        out_flit_q      <= flit_arr[owner_q];
        out_is_header_q <= sel_header;
        out_is_tail_q   <= sel_tail;
      end else if (out_ready) begin
        out_valid_q     <= 1'b0;
        out_flit_q      <= '0;
        out_is_header_q <= 1'b0;
        out_is_tail_q   <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_flit       = out_flit_q;
  assign out_is_header  = out_is_header_q;
  assign out_is_tail    = out_is_tail_q;
  assign owner          = owner_q;
  assign locked         = locked_q;
  assign pkt_cnt        = pkt_cnt_q;
  assign err_mid_header = err_q;

endmodule

// File: tb/tb_noc_inject_rr_arbiter.sv
// Scoreboard bench for noc_inject_rr_arbiter: directed packets per requester,
// expected flit order queued at issue time and checked as the router accepts.
module tb_noc_inject_rr_arbiter;

  localparam int N  = 4;
  localparam int FW = 32;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic          hdr;
    logic          tail;
  } flit_t;

  logic            noc_clk;
  logic            noc_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_flit;
  logic [N-1:0]    req_is_header;
  logic [N-1:0]    req_is_tail;
  logic            out_valid;
  logic            out_ready;
  logic [FW-1:0]   out_flit;
  logic            out_is_header;
  logic            out_is_tail;
  logic [1:0]      owner;
  logic            locked;
  logic [15:0]     pkt_cnt;
  logic            err_mid_header;

  flit_t src_q[N][$];
  flit_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  noc_inject_rr_arbiter #(.NUM_REQ(N), .FLIT_W(FW), .IDX_W(2)) dut (
    .noc_clk        (noc_clk),
    .noc_rst_n      (noc_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_flit       (req_flit),
    .req_is_header  (req_is_header),
    .req_is_tail    (req_is_tail),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_flit       (out_flit),
    .out_is_header  (out_is_header),
    .out_is_tail    (out_is_tail),
    .owner          (owner),
    .locked         (locked),
    .pkt_cnt        (pkt_cnt),
    .err_mid_header (err_mid_header)
  );

  initial begin
    noc_clk = 1'b0;
    forever #5 noc_clk = ~noc_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before 100us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int r, input int p, input int i);
    return 32'hC000_0000 | (FW'(r) << 24) | (FW'(p) << 8) | FW'(i);
  endfunction

  task automatic push(input int r, input logic [FW-1:0] f, input logic h, input logic t,
                      input logic ex);
    flit_t x;
    x.flit = f;
    x.hdr  = h;
    x.tail = t;
    src_q[r].push_back(x);
    if (ex) exp_q.push_back(x);
  endtask

  task automatic pkt(input int r, input int p, input int n);
    for (int i = 0; i < n; i++) push(r, mk(r, p, i), i == 0, i == n - 1, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge noc_clk);
      if (exp_q.size() == 0 && !out_valid && !locked) done = 1'b1;
    end
    check(name, 64'(done), 64'(1));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_fields"}, 64'({out_flit, out_is_header, out_is_tail}), 64'(0));
    check({tag, "_owner"}, 64'(owner), 64'(3));
    check({tag, "_locked"}, 64'(locked), 64'(0));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(0));
    check({tag, "_err"}, 64'(err_mid_header), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge noc_clk);
    #2 noc_rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    #1 chk_reset(tag);
    repeat (2) @(negedge noc_clk);
    out_ready = 1'b1;
    #2 noc_rst_n = 1'b1;
  endtask

  // Source driver: presents each requester's queue head, pops on handshake.
  initial begin : drv
    logic [N-1:0]    acc, v, h, t;
    logic [N*FW-1:0] f;
    req_valid     = '0;
    req_flit      = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    forever begin
      @(negedge noc_clk);
      acc = req_valid & req_ready;
      @(posedge noc_clk);
      #1;
      v = '0; h = '0; t = '0; f = '0;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          v[i] = 1'b1;
          h[i] = src_q[i][0].hdr;
          t[i] = src_q[i][0].tail;
          f[i*FW +: FW] = src_q[i][0].flit;
        end
      end
      req_valid     = v;
      req_is_header = h;
      req_is_tail   = t;
      req_flit      = f;
    end
  end

  // Monitor: every flit taken by the router is compared against the queue head.
  initial begin : mon
    flit_t e;
    forever begin
      @(negedge noc_clk);
      if (noc_rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_flit: got 0x%0h, required no flit", out_flit);
        end else begin
          e = exp_q.pop_front();
          $display("xfer flit=0x%h hdr=%b tail=%b owner=%0d pkt_cnt=%0d",
                   out_flit, out_is_header, out_is_tail, owner, pkt_cnt);
          check("out_flit", 64'(out_flit), 64'(e.flit));
          check("out_markers", 64'({out_is_header, out_is_tail}), 64'({e.hdr, e.tail}));
        end
      end
    end
  end

  initial begin : main
    logic [5:0] exp_v, exp_h, exp_t, exp_l;
    logic       hit;
    int         t_tail, t_r2, pulses;

    noc_rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge noc_clk);
    chk_reset("rst0");
    @(negedge noc_clk);
    #2 noc_rst_n = 1'b1;

    // Test 1: req 0 alone, H/D/T, cycle-accurate latency.
    @(posedge noc_clk);
    #2 pkt(0, 1, 3);
    @(negedge noc_clk);
    exp_v = 6'b011100;
    exp_h = 6'b000100;
    exp_t = 6'b010000;
    exp_l = 6'b001110;
    for (int c = 0; c < 6; c++) begin
      @(negedge noc_clk);
      check($sformatf("t1_cyc%0d_vld_hdr_tail_lock", c),
            64'({out_valid, out_is_header, out_is_tail, locked}),
            64'({exp_v[c], exp_h[c], exp_t[c], exp_l[c]}));
    end
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));

    // Test 2: all four hold headers from a fresh reset -> grants 0,1,2,3,0.
    do_reset("rst1");
    @(posedge noc_clk);
    #2;
    pkt(0, 2, 2);
    pkt(1, 2, 3);
    pkt(2, 2, 2);
    pkt(3, 2, 2);
    pkt(0, 3, 2);
    wait_drain("t2_drain");
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'(5));
    check("t2_owner", 64'(owner), 64'(0));

    // Test 3: req 2 header arrives during req 1's packet.
    @(posedge noc_clk);
    #2 pkt(1, 3, 4);
    repeat (3) @(negedge noc_clk);
    pkt(2, 3, 2);
    t_tail = -1;
    t_r2   = -1;
    for (int c = 0; c < 40 && t_r2 < 0; c++) begin
      @(negedge noc_clk);
      if (req_valid[1] && req_ready[1] && req_is_tail[1]) t_tail = c;
      if (req_ready[2]) t_r2 = c;
    end
    check("t3_tail_seen", 64'(t_tail >= 0), 64'(1));
    check("t3_gap_tail_to_r2", 64'(t_r2 - t_tail), 64'(2));
    check("t3_owner", 64'(owner), 64'(2));
    wait_drain("t3_drain");
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'(7));

    // Test 4: router stalls five cycles mid-packet.
    @(posedge noc_clk);
    #2 pkt(0, 4, 5);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge noc_clk);
      if (out_valid && out_flit == mk(0, 4, 1)) hit = 1'b1;
    end
    check("t4_reach_d1", 64'(hit), 64'(1));
    @(posedge noc_clk);
    #2 out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge noc_clk);
      check($sformatf("t4_hold%0d_out", c),
            64'({out_valid, out_flit, out_is_header, out_is_tail}),
            64'({1'b1, mk(0, 4, 2), 1'b0, 1'b0}));
      check($sformatf("t4_hold%0d_ready", c), 64'(req_ready), 64'(0));
    end
    @(posedge noc_clk);
    #2 out_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'(8));

    // Test 5: single-flit packet, then an orphan data flit in IDLE.
    @(posedge noc_clk);
    #2;
    push(3, mk(3, 5, 0), 1'b1, 1'b1, 1'b1);
    push(3, mk(3, 5, 1), 1'b0, 1'b0, 1'b0);
    wait_drain("t5_drain");
    for (int c = 0; c < 8; c++) begin
      @(negedge noc_clk);
      check($sformatf("t5_orphan%0d_ready_lock", c), 64'({req_ready, locked}), 64'(0));
    end
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'(9));
    src_q[3].delete();

    // Test 6: reset mid-packet, then a mid-packet header.
    @(posedge noc_clk);
    #2;
    out_ready = 1'b0;
    push(0, mk(0, 6, 0), 1'b1, 1'b0, 1'b0);
    push(0, mk(0, 6, 1), 1'b0, 1'b0, 1'b0);
    push(0, mk(0, 6, 2), 1'b0, 1'b1, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge noc_clk);
      if (out_valid) hit = 1'b1;
    end
    check("t6_pre_reset_state", 64'({hit, out_is_header, locked}), 64'(3'b111));
    do_reset("rst2");

    @(posedge noc_clk);
    #2;
    push(1, mk(1, 6, 0), 1'b1, 1'b0, 1'b1);
    push(1, mk(1, 6, 1), 1'b0, 1'b0, 1'b1);
    push(1, mk(1, 6, 2), 1'b1, 1'b0, 1'b1);
    push(1, mk(1, 6, 3), 1'b0, 1'b1, 1'b1);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge noc_clk);
      if (err_mid_header) begin
        pulses++;
        check("t6_err_cycle_out", 64'({out_is_header, locked, out_flit}),
              64'({1'b1, 1'b1, mk(1, 6, 2)}));
      end
      if (c > 3 && exp_q.size() == 0 && !out_valid && !locked) break;
    end
    check("t6_err_pulses", 64'(pulses), 64'(1));
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'(1));
    check("t6_exp_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
